// File: rtl/dec_ram_writer.sv
// Writes a latched message into an external byte RAM and then reads every byte back.
// The written bytes are checked against a lowercase-and-space alphabet, and the read-back data against the message.
module dec_ram_writer #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        msg_in [MSG_LEN],
    input  logic [7:0]        ram_q,
    output logic [ADDR_W-1:0] ram_address,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done,
    output logic              invalid,
    output logic              mismatch
);

    typedef enum logic [2:0] {IDLE, WRITE, VERIFY, CHECK, DONE} state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(MSG_LEN - 1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [7:0]        msg_q [MSG_LEN];
    logic              load_msg;
    logic [7:0]        ram_data_q, ram_data_d;
    logic              ram_wren_q, ram_wren_d;
    logic              invalid_q, invalid_d;
    logic              mismatch_q, mismatch_d;

    logic [ADDR_W-1:0] cur_addr, nxt_addr, prev_addr;

    function automatic logic byte_ok(input logic [7:0] b);
        return ((b >= 8'd97) && (b <= 8'd122)) || (b == 8'd32);
    endfunction

    // The index doubles as the presented RAM address, so the address output is a register.
    assign cur_addr  = idx_q[ADDR_W-1:0];
    assign nxt_addr  = cur_addr + 1'b1;
    assign prev_addr = cur_addr - 1'b1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ram_data_d = ram_data_q;
        ram_wren_d = 1'b0;
        invalid_d  = invalid_q;
        mismatch_d = mismatch_q;
        load_msg   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_msg   = 1'b1;
                    invalid_d  = 1'b0;
                    mismatch_d = 1'b0;
                    idx_d      = '0;
                    ram_wren_d = 1'b1;
                    ram_data_d = msg_in[0];
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                if (!byte_ok(ram_data_q)) begin
                    invalid_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = VERIFY;
                end else begin
                    idx_d      = idx_q + 1'b1;
                    ram_wren_d = 1'b1;
                    ram_data_d = msg_q[nxt_addr];
                end
            end
            VERIFY: begin
                // ram_q now holds the byte for the address presented last cycle.
                if ((idx_q != '0) && (ram_q != msg_q[prev_addr])) begin
                    mismatch_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = CHECK;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            CHECK: begin
                if (ram_q != msg_q[cur_addr]) begin
                    mismatch_d = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ram_data_q <= '0;
            ram_wren_q <= 1'b0;
            invalid_q  <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ram_data_q <= ram_data_d;
            ram_wren_q <= ram_wren_d;
            invalid_q  <= invalid_d;
            mismatch_q <= mismatch_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_msg) begin
            msg_q <= msg_in;
        end
    end

    assign ram_address = cur_addr;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign invalid     = invalid_q;
    assign mismatch    = mismatch_q;

endmodule
